// File: rtl/bnn_neuron_pack.sv
// Accumulates signed partial sums for one neuron and thresholds the total into one binary activation.
// Activations are packed into PACK-bit words and handed off over a valid/ready output register.
module bnn_neuron_pack #(
    parameter  int WIDTH_IN = 8,
    parameter  int ACC_W    = WIDTH_IN + 16,
    parameter  int PACK     = 64,
    localparam int SUM_W    = WIDTH_IN + 11,
    localparam int CNT_W    = $clog2(PACK) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [SUM_W-1:0] in_sum,
    input  logic                    in_last,
    input  logic signed [ACC_W-1:0] threshold,
    input  logic                    in_flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PACK-1:0]         out_bits,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_sat
);

    localparam int IDX_W = $clog2(PACK);
    // One guard bit above the wider operand keeps the raw sum exact before clamping.
    localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    localparam logic signed [EXT_W-1:0] ACC_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    function automatic logic signed [EXT_W-1:0] wide_sum(
        input logic signed [ACC_W-1:0] a,
        input logic signed [SUM_W-1:0] b
    );
        logic signed [EXT_W-1:0] a_ext;
        logic signed [EXT_W-1:0] b_ext;
        a_ext = {{(EXT_W-ACC_W){a[ACC_W-1]}}, a};
        b_ext = {{(EXT_W-SUM_W){b[SUM_W-1]}}, b};
        return a_ext + b_ext;
    endfunction

    function automatic logic is_clamped(input logic signed [EXT_W-1:0] s);
        return (s > ACC_MAX) || (s < ACC_MIN);
    endfunction

    function automatic logic signed [ACC_W-1:0] clamp(input logic signed [EXT_W-1:0] s);
        if (s > ACC_MAX) return ACC_MAX[ACC_W-1:0];
        if (s < ACC_MIN) return ACC_MIN[ACC_W-1:0];
        return s[ACC_W-1:0];
    endfunction

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PACK-1:0]         asm_q, asm_d;
    logic [CNT_W-1:0]        asm_count_q, asm_count_d;
    logic                    word_sat_q, word_sat_d;
    logic                    pend_q, pend_d;
    logic                    out_valid_q, out_valid_d;
    logic [PACK-1:0]         out_bits_q, out_bits_d;
    logic [CNT_W-1:0]        out_count_q, out_count_d;
    logic                    out_sat_q, out_sat_d;

    logic                    accept;
    logic                    flush_go;
    logic                    xfer;
    logic signed [EXT_W-1:0] sum_wide;
    logic signed [ACC_W-1:0] sum_sat;

    assign in_ready  = !pend_q;
    assign out_valid = out_valid_q;
    assign out_bits  = out_bits_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        accept   = in_valid && !pend_q;
        flush_go = in_flush && !in_valid && !pend_q && (idx_q != '0);
        xfer     = pend_q && (!out_valid_q || out_ready);
        sum_wide = wide_sum(acc_q, in_sum);
        sum_sat  = clamp(sum_wide);

        acc_d       = acc_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        asm_count_d = asm_count_q;
        word_sat_d  = word_sat_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;

        if (accept) begin
            if (is_clamped(sum_wide)) word_sat_d = 1'b1;
            if (in_last) begin
                asm_d[idx_q] = (sum_sat >= threshold);
                acc_d        = '0;
                idx_d        = idx_q + 1'b1;
                if (idx_q == IDX_W'(PACK - 1)) begin
                    pend_d      = 1'b1;
                    idx_d       = '0;
                    asm_count_d = CNT_W'(PACK);
                end
            end else begin
                acc_d = sum_sat;
            end
        end else if (flush_go) begin
            pend_d      = 1'b1;
            asm_count_d = CNT_W'(idx_q);
            idx_d       = '0;
        end

        // Transfer only happens while pend is set, so it never collides with an accept.
        if (xfer) begin
            out_valid_d = 1'b1;
            out_bits_d  = asm_q;
            out_count_d = asm_count_q;
            out_sat_d   = word_sat_q;
            asm_d       = '0;
            word_sat_d  = 1'b0;
            pend_d      = 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            idx_q       <= '0;
            asm_q       <= '0;
            asm_count_q <= '0;
            word_sat_q  <= 1'b0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            asm_count_q <= asm_count_d;
            word_sat_q  <= word_sat_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_bnn_neuron_pack.sv
// Bench for bnn_neuron_pack (PACK=4, ACC_W=12): vector table, directed corner sequences,
// and randomized traffic scored against a transaction-level model.
module tb_bnn_neuron_pack;

    localparam int WIDTH_IN = 8;
    localparam int ACC_W    = 12;
    localparam int PACK     = 4;
    localparam int SUM_W    = WIDTH_IN + 11;
    localparam int CNT_W    = $clog2(PACK) + 1;
    localparam int AMAX     = 2047;
    localparam int AMIN     = -2048;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [SUM_W-1:0] in_sum = '0;
    logic                    in_last = 1'b0;
    logic signed [ACC_W-1:0] threshold = '0;
    logic                    in_flush = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [PACK-1:0]         out_bits;
    logic [CNT_W-1:0]        out_count;
    logic                    out_sat;

    bnn_neuron_pack #(.WIDTH_IN(WIDTH_IN), .ACC_W(ACC_W), .PACK(PACK)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_last(in_last),
        .threshold(threshold), .in_flush(in_flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bits(out_bits), .out_count(out_count), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PACK-1:0] bits;
        int              count;
        bit              sat;
    } word_t;

    typedef struct {
        int sum;
        int thr;
        bit exp_bit;
    } vec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    word_t exp_q[$];
    int    words_seen = 0;
    logic [PACK-1:0] last_bits;
    int    last_count;
    bit    last_sat;
    bit    rand_mode = 1'b0;

    // Reference model state: neuron total, word under construction.
    int              m_acc = 0;
    int              m_idx = 0;
    logic [PACK-1:0] m_bits = '0;
    bit              m_sat = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_push(input int cnt);
        word_t w;
        w.bits = m_bits; w.count = cnt; w.sat = m_sat;
        exp_q.push_back(w);
        m_bits = '0; m_sat = 1'b0; m_idx = 0;
    endtask

    task automatic model_accept(input int s, input bit last, input int thr);
        m_acc = m_acc + s;
        if (m_acc > AMAX) begin m_acc = AMAX; m_sat = 1'b1; end
        if (m_acc < AMIN) begin m_acc = AMIN; m_sat = 1'b1; end
        if (last) begin
            if (m_acc >= thr) m_bits[m_idx] = 1'b1;
            m_acc = 0;
            m_idx++;
            if (m_idx == PACK) model_push(PACK);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_acc = 0; m_idx = 0; m_bits = '0; m_sat = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input bit last, input int thr);
        int guard = 0;
        in_valid  = 1'b1;
        in_sum    = SUM_W'(s);
        in_last   = last;
        threshold = ACC_W'(thr);
        while (!in_ready && guard < 200) begin
            step();
            guard++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(s, last, thr);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic flush();
        int guard = 0;
        in_flush = 1'b1;
        while (!in_ready && guard < 200) begin
            step();
            guard++;
        end
        if (!in_ready) begin
            check("flush_timeout", 0, 1);
            in_flush = 1'b0;
            return;
        end
        @(posedge clk);
        if (m_idx > 0) model_push(m_idx);
        #1;
        in_flush = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            step();
            guard++;
        end
        if (exp_q.size() != 0 || out_valid) check("drain_timeout", 0, 1);
    endtask

    // Word scoreboard: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got bits %b count %0d, none required", out_bits, out_count);
            end else begin
                word_t e;
                e = exp_q.pop_front();
                check("word_bits", out_bits, e.bits);
                check("word_count", out_count, e.count);
                check("word_sat", out_sat, e.sat);
            end
            last_bits  = out_bits;
            last_count = out_count;
            last_sat   = out_sat;
            words_seen++;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = ($urandom_range(0, 1) == 1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            tbl [8];
        logic [PACK-1:0] exp_word;
        int              ws;

        tbl = '{'{5, 0, 1}, '{-3, 0, 0}, '{0, 0, 1}, '{7, 0, 1},
                '{100, 99, 1}, '{100, 101, 0}, '{-50, -50, 1}, '{-51, -50, 0}};

        repeat (3) step();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bits", out_bits, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_sat", out_sat, 0);

        // Latency: pend one cycle after the 4th accept, out_valid the cycle after.
        out_ready = 1'b1;
        send(5, 1, 0); send(-3, 1, 0); send(0, 1, 0); send(7, 1, 0);
        check("lat_pend_in_ready", in_ready, 0);
        check("lat_out_valid_early", out_valid, 0);
        step();
        check("lat_out_valid", out_valid, 1);
        check("lat_out_bits", out_bits, 4'b1101);
        check("lat_out_count", out_count, 4);
        check("lat_out_sat", out_sat, 0);
        check("lat_in_ready_back", in_ready, 1);
        drain();

        exp_word = '0;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].sum, 1'b1, tbl[i].thr);
            exp_word[i % PACK] = tbl[i].exp_bit;
            if (i % PACK == PACK - 1) begin
                drain();
                check("tbl_word", last_bits, exp_word);
                exp_word = '0;
            end
        end

        // Multi-chunk neurons; the third neuron must not inherit any leftover total.
        send(100, 0, 0); send(-40, 0, 0); send(-70, 1, -10);
        send(100, 0, 0); send(-40, 0, 0); send(-70, 1, -9);
        send(5, 1, 5);
        send(-1, 1, 0);
        drain();
        check("multi_bits", last_bits, 4'b0101);

        for (int i = 0; i < 20; i++) send(1000, 0, 0);
        send(0, 1, 0); send(0, 1, 0); send(0, 1, 0); send(0, 1, 0);
        drain();
        check("sat_bits", last_bits, 4'b1111);
        check("sat_flag", last_sat, 1);
        for (int i = 0; i < PACK; i++) send(-5, 1, 0);
        drain();
        check("sat_next_clear", last_sat, 0);

        // Backpressure: two words complete while the consumer stalls.
        out_ready = 1'b0;
        ws = words_seen;
        send(1, 1, 0); send(-1, 1, 0); send(1, 1, 0); send(-1, 1, 0);
        send(-1, 1, 0); send(-1, 1, 0); send(1, 1, 0); send(1, 1, 0);
        step(); step();
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        check("bp_hold_bits", out_bits, 4'b0101);
        repeat (5) step();
        check("bp_hold_bits_late", out_bits, 4'b0101);
        check("bp_hold_count", out_count, 4);
        check("bp_in_ready_late", in_ready, 0);
        drain();
        check("bp_words", words_seen - ws, 2);
        check("bp_last_bits", last_bits, 4'b1100);

        send(5, 1, 0); send(-5, 1, 0); send(5, 1, 0);
        flush();
        drain();
        check("flush_bits", last_bits, 4'b0101);
        check("flush_count", last_count, 3);
        ws = words_seen;
        flush();
        repeat (5) step();
        check("flush_empty_words", words_seen, ws);
        check("flush_empty_valid", out_valid, 0);

        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int r;
            int s;
            r = int'($urandom_range(0, 19));
            s = int'($urandom_range(0, 3000)) - 1500;
            if (r == 1) s = ($urandom_range(0, 1) == 1) ? 4000 : -4000;
            if (r == 0) flush();
            else send(s, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 1000)) - 500);
        end
        step();
        rand_mode = 1'b0;
        step();
        flush();
        drain();

        // Reset with a word held at the output and a neuron half accumulated.
        out_ready = 1'b0;
        send(5, 1, 0); send(5, 1, 0); send(5, 1, 0); send(5, 1, 0);
        step(); step();
        check("rstmid_out_valid_before", out_valid, 1);
        send(1000, 0, 0); send(1000, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_in_ready", in_ready, 1);
        ws = words_seen;
        out_ready = 1'b1;
        send(-5, 1, 0);
        flush();
        drain();
        check("rstmid_words", words_seen - ws, 1);
        check("rstmid_bits", last_bits, 4'b0000);
        check("rstmid_count", last_count, 1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bnn_neuron_pack.md
# bnn_neuron_pack

Downstream stage of the 64-input adder tree: accumulates successive signed partial sums belonging to one neuron, compares the neuron total against a per-neuron threshold to produce one binary activation, and packs consecutive activations into a PACK-bit word for the next layer's input buffer. Valid/ready handshake on both sides. Saturating accumulator with a per-word saturation flag.

## Interface
- WIDTH_IN, 8, activation/weight datapath width; sets the incoming sum width to WIDTH_IN+11.
- ACC_W, WIDTH_IN+16, accumulator and threshold width (signed).
- PACK, 64, activation bits per output word (power of two, ≥2).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_sum/in_last/threshold valid.
- in_ready  out  1  block accepts input this cycle.
- in_sum  in  WIDTH_IN+11 (signed)  partial sum from the adder tree.
- in_last  in  1  final partial sum of the current neuron.
- threshold  in  ACC_W (signed)  neuron threshold; used only on the accepted in_last beat.
- in_flush  in  1  emit the partially filled word; honoured only when in_ready=1 and in_valid=0.
- out_valid  out  1  out_bits/out_count/out_sat valid.
- out_ready  in  1  consumer takes the word.
- out_bits  out  PACK  packed activations; neuron k of the word in bit k.
- out_count  out  $clog2(PACK)+1  number of valid bits (PACK for a full word).
- out_sat  out  1  some neuron in this word saturated the accumulator.

## Operation
- Accept = in_valid && in_ready. in_ready = !pend (pend: assembly word complete, not yet moved to output register).
- Accumulator acc (ACC_W, signed), starts at 0. On accept: sum = acc + sign-extended in_sum, clamped to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. Clamp sets word_sat.
- Accept with in_last=0: acc ← sum. Accept with in_last=1: bit = (sum ≥ threshold), signed compare. Bit written to asm[idx], acc ← 0, idx ← idx+1. Unwritten bits of asm stay 0.
- When the written bit is at idx=PACK−1: pend ← 1, idx ← 0, asm_count ← PACK.
- in_flush (accepted as defined, idx>0, pend=0): pend ← 1 with asm_count = idx, idx ← 0. in_flush with idx=0 is ignored. A mid-neuron acc is not flushed; it keeps accumulating.
- Transfer: when pend && (!out_valid || out_ready): out_bits ← asm, out_count ← asm_count, out_sat ← word_sat, out_valid ← 1. asm, word_sat and pend are cleared in the same cycle. in_ready returns to 1 the next cycle.
- out_valid && out_ready && no transfer → out_valid ← 0. out_bits/out_count/out_sat are held stable while out_valid && !out_ready.
- rst: acc, idx, asm, word_sat, pend, out_valid, out_bits, out_count, out_sat all ← 0. in_ready = 1 on the first cycle after reset. Mid-word reset discards partial accumulation and any pending or unconsumed word.

## Timing
- Throughput: one partial sum per cycle while in_ready=1.
- Latency: completing in_last accepted in cycle t → pend at t+1 → out_valid at t+2 if the output register is free or draining at t+1.
- in_ready is low for at least one cycle per completed word, and for as long as the pending transfer is blocked.
- Back-to-back words with out_ready tied high: one stall cycle per PACK neurons.
- in_flush and a completing in_last cannot coincide: in_flush requires in_valid=0.

## Test plan
- PACK=4, single-chunk neurons: in_sum = 5, −3, 0, 7 with threshold 0, all in_last → out_bits=4'b1101, out_count=4, out_sat=0, out_valid 2 cycles after the 4th accept.
- Multi-chunk neuron: sums 100, −40, −70 (last), threshold −10 → total −10, bit=1. Repeat with threshold −9 → bit=0. The next neuron's acc starts at 0.
- Saturation, ACC_W=12: 20 accepts of +1000 then last with threshold 0 → acc clamps at 2047, bit=1, out_sat=1 for that word only; the next word has out_sat=0.
- Backpressure: out_ready=0 while two words complete → first word held unchanged, in_ready=0 after the second word completes until out_ready=1; both words are delivered in order, none lost.
- Flush: 3 neurons (bits 1,0,1), then in_flush → out_bits=…0101, out_count=3. in_flush with idx=0 produces no output.
- Reset mid-operation: assert rst after 2 chunks of a neuron and with out_valid=1 → next cycle out_valid=0, in_ready=1. The following neuron's result ignores the pre-reset chunks.
